mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, memory access latency in cycles (legal 1..15).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports if_req input 1, if_addr input AW; instruction-fetch read request.
REQ-007 SHALL have ports if_rdata output DW, if_ack output 1; fetch read data and one-cycle completion pulse.
REQ-008 SHALL have ports dm_req input 1, dm_we input 1, dm_addr input AW, dm_wdata input DW; data-memory request.
REQ-009 SHALL have ports dm_rdata output DW, dm_ack output 1; data read result and one-cycle completion pulse.
REQ-010 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output AW, mem_wdata output DW, mem_rdata input DW; single shared memory port.
REQ-011 SHALL have port stall output 1; pipeline freeze request to the hazard logic.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM.
REQ-013 In IDLE, an effective request (req high and own ack not high this cycle) SHALL be granted at the next edge, capturing addr/we/wdata into registers.
REQ-014 Transition into a BUSY state SHALL load counter with LAT-1.
REQ-015 In BUSY states mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL come from captured registers; mem_we=0 for BUSY_IF.
REQ-016 In IDLE, mem_en, mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-017 In BUSY with counter>0 the counter SHALL decrement; with counter==0, mem_rdata SHALL be registered into the owner's rdata, owner's ack SHALL be 1 next cycle, and state SHALL return to IDLE.
REQ-018 Request-seen (cycle T) to ack SHALL be exactly LAT+1 cycles (ack in cycle T+LAT+1).
REQ-019 A new grant SHALL be allowed in the same cycle an ack is high (back-to-back), excluding the acked requester.
REQ-020 On writes, dm_rdata SHALL hold its previous value; dm_ack SHALL still pulse.
REQ-021 Requests arriving during BUSY SHALL wait; requests dropped mid-transaction SHALL NOT abort it and the ack SHALL still pulse.
REQ-022 Simultaneous if_req and dm_req in IDLE SHALL grant dm (older instruction wins) unless REQ-028 applies.
REQ-023 stall SHALL equal (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
REQ-024 Acks SHALL never be high for both requesters in the same cycle.

Reset
REQ-025 rst SHALL force IDLE, counter=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, captured addr/wdata/we=0 at the next edge.
REQ-026 rst during BUSY SHALL abort the access; no ack SHALL be produced for it.
REQ-027 The round-robin pointer (REQ-028) SHALL reset to "last granted = IF" so dm wins first contention.

Configuration
REQ-028 With MEM_ARB_ROUND_ROBIN_EN defined, contention SHALL grant the requester not granted most recently; without it, fixed dm priority (REQ-022) and no pointer register.

Structure
REQ-029 State enum, LAT counter width (4) and default AW/DW SHALL live in shared package mips_mem_pkg.
REQ-030 No sub-module SHALL be required; counter and FSM SHALL be inline.

Verification (LAT=2)
REQ-031 if_req=1, if_addr=0x40, mem_rdata=0x8C010004 -> mem_en high 2 cycles at 0x40, if_ack pulse 3 cycles after request, if_rdata=0x8C010004.
REQ-032 dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_we=1 two cycles, dm_ack pulse, dm_rdata unchanged.
REQ-033 if_req and dm_req together, held until ack -> dm acked first, if granted in dm_ack cycle, if_ack 3 cycles later; stall high throughout; with MEM_ARB_ROUND_ROBIN_EN, second contention grants if first.
REQ-034 rst pulsed in second BUSY cycle -> next cycle IDLE, mem_en=0, no ack ever issued for aborted access.
REQ-035 dm_req dropped after grant -> access completes, dm_ack pulses once, stall low after drop.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared FSM state type, latency counter width and default bus widths for mem_port_arbiter.
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  localparam int CW = 4;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data requesters.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed data priority.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic we_r, idle, done, if_eff, dm_eff, grant_if, grant_dm, grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dm;
`endif
  always_comb begin
    idle = state == IDLE;
    done = !idle && cnt == '0;
    if_eff = if_req & ~if_ack;
    dm_eff = dm_req & ~dm_ack;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_dm = idle & dm_eff & (~if_eff | ~last_dm);
`else
    grant_dm = idle & dm_eff;
`endif
    grant_if = idle & if_eff & ~grant_dm;
    grant = grant_if | grant_dm;
    state_n = idle ? (grant_dm ? BUSY_DM : grant_if ? BUSY_IF : IDLE) : done ? IDLE : state;
    stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);
    mem_en = !idle;
    mem_we = state == BUSY_DM && we_r;
    mem_addr = addr_r;
    mem_wdata = wdata_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      we_r <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dm <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if_ack <= done && state == BUSY_IF;
      dm_ack <= done && state == BUSY_DM;
      cnt <= grant ? CW'(LAT - 1) : (!idle && cnt != '0) ? cnt - 1'b1 : cnt;
      if (grant) begin
        addr_r <= grant_dm ? dm_addr : if_addr;
        wdata_r <= grant_dm ? dm_wdata : wdata_r;
        we_r <= grant_dm & dm_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_dm <= grant_dm;
`endif
      end
      if (done && state == BUSY_IF) if_rdata <= mem_rdata;
      if (done && state == BUSY_DM && !we_r) dm_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with an ack scoreboard; memory returns addr ^ 0x8C010044.
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ack, dm_ack, mem_en, mem_we, stall;
  int cyc = 0, n_checks = 0, n_fail = 0;
  typedef struct {bit dm; logic [31:0] rdata; int at;} exp_t;
  exp_t sb[$];

  mem_port_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  assign mem_rdata = mem_addr ^ 32'h8C010044;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_ack && dm_ack) check(0, "both_acks", 32'd1, 32'd0);
    else if (if_ack || dm_ack) begin
      if (sb.size() == 0) check(0, "unexpected_ack", {31'd0, dm_ack}, 32'hFFFFFFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        check(dm_ack == e.dm, "ack_owner", {31'd0, dm_ack}, {31'd0, e.dm});
        check(e.at == cyc, "ack_cycle", cyc, e.at);
        check((e.dm ? dm_rdata : if_rdata) == e.rdata, e.dm ? "dm_rdata" : "if_rdata",
              e.dm ? dm_rdata : if_rdata, e.rdata);
      end
    end
  end

  task automatic wait_drop(input bit dm);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(dm ? dm_ack : if_ack) && n < 12);
    if (n >= 12) check(0, dm ? "dm_ack_timeout" : "if_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (dm) dm_req = 0; else if_req = 0;
  endtask

  task automatic do_req(input bit dm, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input bit drop);
    int t;
    @(posedge clk); #1;
    t = cyc;
    if (dm) begin dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    sb.push_back('{dm, exp, t + 3});
    @(negedge clk);
    check(stall == 1, "stall_req_cycle", {31'd0, stall}, 32'd1);
    check(mem_en == 0, "mem_en_req_cycle", {31'd0, mem_en}, 32'd0);
    if (drop) begin @(posedge clk); #1; dm_req = 0; if_req = 0; end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check(mem_en == 1, "mem_en_busy", {31'd0, mem_en}, 32'd1);
      check(mem_we == we, "mem_we_busy", {31'd0, mem_we}, {31'd0, we});
      check(mem_addr == addr, "mem_addr_busy", mem_addr, addr);
      if (we) check(mem_wdata == wdata, "mem_wdata_busy", mem_wdata, wdata);
      check(stall == !drop, "stall_busy", {31'd0, stall}, {31'd0, !drop});
    end
    wait_drop(dm);
    check(mem_en == 0, "mem_en_after", {31'd0, mem_en}, 32'd0);
  endtask

  task automatic contend(input bit if_first, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ie, input logic [31:0] de);
    int t;
    @(posedge clk); #1;
    t = cyc;
    if_req = 1; if_addr = ia; dm_req = 1; dm_we = 0; dm_addr = da;
    if (if_first) begin sb.push_back('{0, ie, t + 3}); sb.push_back('{1, de, t + 6}); end
    else begin sb.push_back('{1, de, t + 3}); sb.push_back('{0, ie, t + 6}); end
    fork
      wait_drop(0);
      wait_drop(1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check(stall == 1, "stall_contention", {31'd0, stall}, 32'd1);
      end
    join
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check(mem_en == 0, "rst_mem_en", {31'd0, mem_en}, 32'd0);
    check(!if_ack && !dm_ack, "rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    check(if_rdata == 0, "rst_if_rdata", if_rdata, 32'd0);
    check(dm_rdata == 0, "rst_dm_rdata", dm_rdata, 32'd0);
    check(mem_addr == 0, "rst_mem_addr", mem_addr, 32'd0);
    check(stall == 0, "rst_stall", {31'd0, stall}, 32'd0);
    do_req(0, 0, 32'h40, 32'h0, 32'h8C010004, 0);
    do_req(1, 0, 32'h200, 32'h0, 32'h8C010244, 1);
    do_req(1, 1, 32'h100, 32'hDEADBEEF, 32'h8C010244, 0);
    check(mem_addr == 32'h100, "mem_addr_hold", mem_addr, 32'h100);
    contend(0, 32'h80, 32'h204, 32'h8C0100C4, 32'h8C010240);
    do_req(1, 1, 32'h104, 32'h12345678, 32'h8C010240, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    contend(1, 32'h84, 32'h208, 32'h8C0100C0, 32'h8C01024C);
`else
    contend(0, 32'h84, 32'h208, 32'h8C0100C0, 32'h8C01024C);
`endif
    @(posedge clk); #1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; dm_req = 0;
    @(negedge clk);
    check(mem_en == 1, "busy_before_rst", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check(mem_en == 0, "rst_abort_mem_en", {31'd0, mem_en}, 32'd0);
    check(dm_rdata == 0, "rst_abort_dm_rdata", dm_rdata, 32'd0);
    check(if_rdata == 0, "rst_abort_if_rdata", if_rdata, 32'd0);
    check(mem_addr == 0, "rst_abort_mem_addr", mem_addr, 32'd0);
    repeat (8) @(negedge clk);
    check(sb.size() == 0, "scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
